regfile_wb_arbiter: RTL

//  Shares the single register-file write port (WE3/A3/WD3) between two writeback requesters:

---
 rtl/regfile_wb_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port (we3/a3/wd3) between two
//   writeback requesters. Each requester has a DEPTH-entry FIFO, and a
//   round-robin arbiter drains one entry per cycle into a registered output
//   stage. The register file commits that output on the following negedge.
//   Entries addressed to R0 are dropped silently. Entries addressed to R15
//   (the PC, not stored here) are dropped and flagged with illegal_wr.
// Ports
//   clk, rst                  clock (posedge), async active-high reset
//   a_valid/a_ready/a_addr/a_data   channel A (ALU / pipeline writeback)
//   b_valid/b_ready/b_addr/b_data   channel B (memory load / coprocessor)
//   we3, a3, wd3              registered register-file write port
//   illegal_wr                one-cycle pulse when an R15 entry is discarded
// Optional feature (macro RF_HAZARD_EN)
//   Adds rd_a1/rd_a2 read addresses and a combinational hazard output that
//   flags reads of a register with a write still queued or in the output stage.
module regfile_wb_arbiter #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = 32,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_data,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_data,
   output logic          we3,
   output logic [AW-1:0] a3,
   output logic [DW-1:0] wd3,
`ifdef RF_HAZARD_EN
   input  logic [AW-1:0] rd_a1,
   input  logic [AW-1:0] rd_a2,
   output logic          hazard,
`endif
   output logic          illegal_wr
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [AW-1:0] ADDR_PC   = AW'(15);
   localparam logic [AW-1:0] ADDR_ZERO = AW'(0);

   typedef enum logic {FAV_A = 1'b0, FAV_B = 1'b1} rr_e;

   // FIFO storage and bookkeeping
   logic [AW-1:0] r_a_addr_mem [DEPTH];
   logic [DW-1:0] r_a_data_mem [DEPTH];
   logic [AW-1:0] r_b_addr_mem [DEPTH];
   logic [DW-1:0] r_b_data_mem [DEPTH];
   logic [PW-1:0] r_a_wp, r_a_rp, r_b_wp, r_b_rp;
   logic [CW-1:0] r_a_cnt, r_b_cnt;

   rr_e           r_rr, w_rr_next;
   logic          w_a_push, w_b_push, w_a_ne, w_b_ne;
   logic          w_grant_a, w_grant_b, w_pop;
   logic [AW-1:0] w_pop_addr;
   logic [DW-1:0] w_pop_data;

   // Ready depends only on the count: a same-cycle pop never frees a slot early
   assign a_ready  = (r_a_cnt != CW'(DEPTH));
   assign b_ready  = (r_b_cnt != CW'(DEPTH));
   assign w_a_push = a_valid && a_ready;
   assign w_b_push = b_valid && b_ready;
   assign w_a_ne   = (r_a_cnt != CW'(0));
   assign w_b_ne   = (r_b_cnt != CW'(0));
   assign w_pop    = w_grant_a || w_grant_b;

   // Round-robin state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rr <= FAV_A;
      else     r_rr <= w_rr_next;
   end

   // Grant and next favoured channel; any grant hands priority to the other side
   always_comb begin
      w_rr_next = r_rr;
      w_grant_a = 1'b0;
      w_grant_b = 1'b0;
      if (w_a_ne && (!w_b_ne || (r_rr == FAV_A))) begin
         w_grant_a = 1'b1;
         w_rr_next = FAV_B;
      end else if (w_b_ne) begin
         w_grant_b = 1'b1;
         w_rr_next = FAV_A;
      end
   end

   // Head-of-queue select for the granted channel
   always_comb begin
      w_pop_addr = r_a_addr_mem[r_a_rp];
      w_pop_data = r_a_data_mem[r_a_rp];
      if (w_grant_b) begin
         w_pop_addr = r_b_addr_mem[r_b_rp];
         w_pop_data = r_b_data_mem[r_b_rp];
      end
   end

   // FIFO payload storage (no reset needed: validity is tracked by the counts)
   always_ff @(posedge clk) begin
      if (w_a_push) begin
         r_a_addr_mem[r_a_wp] <= a_addr;
         r_a_data_mem[r_a_wp] <= a_data;
      end
      if (w_b_push) begin
         r_b_addr_mem[r_b_wp] <= b_addr;
         r_b_data_mem[r_b_wp] <= b_data;
      end
   end

   // FIFO pointers and counts; pointers wrap naturally since DEPTH is a power of 2
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_wp  <= '0;
         r_a_rp  <= '0;
         r_a_cnt <= '0;
         r_b_wp  <= '0;
         r_b_rp  <= '0;
         r_b_cnt <= '0;
      end else begin
         if (w_a_push)  r_a_wp <= r_a_wp + PW'(1);
         if (w_grant_a) r_a_rp <= r_a_rp + PW'(1);
         if (w_b_push)  r_b_wp <= r_b_wp + PW'(1);
         if (w_grant_b) r_b_rp <= r_b_rp + PW'(1);
         r_a_cnt <= r_a_cnt + CW'(w_a_push) - CW'(w_grant_a);
         r_b_cnt <= r_b_cnt + CW'(w_b_push) - CW'(w_grant_b);
      end
   end

   // Registered write port; R0 and R15 entries are consumed without a write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we3        <= 1'b0;
         a3         <= '0;
         wd3        <= '0;
         illegal_wr <= 1'b0;
      end else begin
         we3        <= 1'b0;
         illegal_wr <= 1'b0;
         if (w_pop) begin
            a3         <= w_pop_addr;
            wd3        <= w_pop_data;
            we3        <= (w_pop_addr != ADDR_ZERO) && (w_pop_addr != ADDR_PC);
            illegal_wr <= (w_pop_addr == ADDR_PC);
         end
      end
   end

`ifdef RF_HAZARD_EN
   logic [DEPTH-1:0] w_a_occ, w_b_occ;
   logic             w_hit;

   // Slot i is occupied when its distance from the read pointer is below the count
   always_comb begin
      w_a_occ = '0;
      w_b_occ = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         w_a_occ[i] = (CW'(PW'(PW'(i) - r_a_rp)) < r_a_cnt);
         w_b_occ[i] = (CW'(PW'(PW'(i) - r_b_rp)) < r_b_cnt);
      end
   end

   // Compare both read ports against queued entries and the in-flight write
   always_comb begin
      w_hit = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (w_a_occ[i] && ((rd_a1 == r_a_addr_mem[i]) || (rd_a2 == r_a_addr_mem[i]))) begin
            w_hit = w_hit | (((rd_a1 == r_a_addr_mem[i]) && (rd_a1 != ADDR_ZERO) && (rd_a1 != ADDR_PC)) ||
                             ((rd_a2 == r_a_addr_mem[i]) && (rd_a2 != ADDR_ZERO) && (rd_a2 != ADDR_PC)));
         end
         if (w_b_occ[i] && ((rd_a1 == r_b_addr_mem[i]) || (rd_a2 == r_b_addr_mem[i]))) begin
            w_hit = w_hit | (((rd_a1 == r_b_addr_mem[i]) && (rd_a1 != ADDR_ZERO) && (rd_a1 != ADDR_PC)) ||
                             ((rd_a2 == r_b_addr_mem[i]) && (rd_a2 != ADDR_ZERO) && (rd_a2 != ADDR_PC)));
         end
      end
      if (we3 && (((rd_a1 == a3) && (rd_a1 != ADDR_ZERO) && (rd_a1 != ADDR_PC)) ||
                  ((rd_a2 == a3) && (rd_a2 != ADDR_ZERO) && (rd_a2 != ADDR_PC)))) begin
         w_hit = 1'b1;
      end
   end

   assign hazard = !rst && w_hit;
`endif

endmodule
